// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes, a persistent carry flag
// and iterative (one bit per cycle) shift/rotate execution.
module alu_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [5:0]       Status,
  output logic             err
);

  localparam int unsigned W1 = WIDTH + 1;

  localparam logic [4:0] OP_INC = 5'b00001;
  localparam logic [4:0] OP_DEC = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SBB = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_NOT = 5'b01011;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [5:0]       status_q;
  logic             err_q;
  logic             cf_q;
  logic [WIDTH-1:0] sh_val_q;
  logic [SHW-1:0]   sh_cnt_q;
  logic [2:0]       sh_op_q;
  logic             sh_cf_q;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] ar_b;
  logic             ar_cin, ar_sub;
  logic [WIDTH:0]   ar_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_vf, alu_af, alu_err;
  logic [5:0]       alu_status;
  logic [WIDTH-1:0] step_val;
  logic             step_cf;
  logic [5:0]       sh_status;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_shift  = (F[4:3] == 2'b10);
  assign amt       = B[SHW-1:0];
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Status    = status_q;
  assign err       = err_q;

  // Single-cycle datapath: arithmetic, logic, zero-amount shifts, illegal ops
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    alu_af  = 1'b0;
    alu_err = 1'b0;
    ar_b    = (F == OP_INC || F == OP_DEC) ? WIDTH'(1) : B;
    ar_sub  = (F == OP_DEC || F == OP_SUB || F == OP_SBB);
    ar_cin  = (F == OP_ADC || F == OP_SBB) ? cf_q : 1'b0;
    ar_sum  = ar_sub ? ({1'b0, A} - {1'b0, ar_b} - W1'(ar_cin))
                     : ({1'b0, A} + {1'b0, ar_b} + W1'(ar_cin));
    case (F)
      OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
        alu_res = ar_sum[WIDTH-1:0];
        alu_cf  = ar_sum[WIDTH];
        // carry/borrow into bit 4 is the carry/borrow out of bit 3
        alu_af  = A[4] ^ ar_b[4] ^ ar_sum[4];
        if (ar_sub)
          alu_vf = (A[WIDTH-1] != ar_b[WIDTH-1]) && (ar_sum[WIDTH-1] != A[WIDTH-1]);
        else
          alu_vf = (A[WIDTH-1] == ar_b[WIDTH-1]) && (ar_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_NOT: alu_res = ~A;
      default: begin
        if (is_shift) begin
          // only the zero-amount case completes here; result is A, carry kept
          alu_res = A;
          alu_cf  = cf_q;
        end else begin
          alu_err = 1'b1;
        end
      end
    endcase
    alu_status = alu_err ? 6'b010010
                         : {alu_cf, (alu_res == '0), alu_res[WIDTH-1], alu_vf,
                            ~^alu_res, alu_af};
  end

  // One-bit shift/rotate step on the working register
  always_comb begin
    step_val = sh_val_q;
    step_cf  = sh_cf_q;
    case (sh_op_q)
      3'b000, 3'b010: begin step_cf = sh_val_q[WIDTH-1]; step_val = {sh_val_q[WIDTH-2:0], 1'b0}; end
      3'b001: begin step_cf = sh_val_q[0]; step_val = {1'b0, sh_val_q[WIDTH-1:1]}; end
      3'b011: begin step_cf = sh_val_q[0]; step_val = {sh_val_q[WIDTH-1], sh_val_q[WIDTH-1:1]}; end
      3'b100: begin step_cf = sh_val_q[WIDTH-1]; step_val = {sh_val_q[WIDTH-2:0], sh_val_q[WIDTH-1]}; end
      3'b101: begin step_cf = sh_val_q[0]; step_val = {sh_val_q[0], sh_val_q[WIDTH-1:1]}; end
      3'b110: begin step_cf = sh_val_q[WIDTH-1]; step_val = {sh_val_q[WIDTH-2:0], sh_cf_q}; end
      default: begin step_cf = sh_val_q[0]; step_val = {sh_cf_q, sh_val_q[WIDTH-1:1]}; end
    endcase
    sh_status = {step_cf, (step_val == '0), step_val[WIDTH-1], 1'b0, ~^step_val, 1'b0};
  end

  // Next-state: enter SHIFT for a nonzero amount, leave after the last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_shift && amt != '0) state_d = S_SHIFT;
      S_SHIFT: if (sh_cnt_q == SHW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Output, stored-flag and shift working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
      err_q       <= 1'b0;
      cf_q        <= 1'b0;
      sh_val_q    <= '0;
      sh_cnt_q    <= '0;
      sh_op_q     <= '0;
      sh_cf_q     <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (accept) begin
          if (is_shift && amt != '0) begin
            sh_val_q <= A;
            sh_cnt_q <= amt;
            sh_op_q  <= F[2:0];
            sh_cf_q  <= cf_q;
          end else begin
            result_q    <= alu_res;
            status_q    <= alu_status;
            err_q       <= alu_err;
            cf_q        <= alu_status[5];
            out_valid_q <= 1'b1;
          end
        end
      end else begin
        sh_val_q <= step_val;
        sh_cf_q  <= step_cf;
        sh_cnt_q <= sh_cnt_q - SHW'(1);
        if (sh_cnt_q == SHW'(1)) begin
          result_q    <= step_val;
          status_q    <= sh_status;
          err_q       <= 1'b0;
          cf_q        <= step_cf;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule
